muldiv_sequencer: RTL and testbench
===================================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous active-high reset.
REQ-004 start  input  1  request a multiply or divide; accepted only when busy=0.
REQ-005 alu_control  input  4  operation code, sampled with start: MULT 4'b0000, MULTU 4'b1001, DIV 4'b1101, DIVU 4'b1100; any other code with start SHALL be ignored.
REQ-006 op1, op2  input  32 each  operands, sampled on accept; op1 is the dividend, op2 the divisor.
REQ-007 abort  input  1  cancel the in-flight operation.
REQ-008 wr_hi, wr_lo  input  1 each  MTHI/MTLO write strobes.
REQ-009 wr_data  input  32  MTHI/MTLO data.
REQ-010 busy  output  1  an operation is in flight.
REQ-011 done  output  1  one-cycle pulse in the cycle HI/LO are committed.
REQ-012 high, low  output  32 each  architectural HI and LO registers.

Function
REQ-013 FSM states SHALL be IDLE, PREP, RUN and FIX; busy=1 in every state except IDLE.
REQ-014 IDLE SHALL move to PREP on start with a legal opcode, latching operands and the op.
REQ-015 PREP (1 cycle) SHALL convert signed operands to magnitudes, record the result signs, and clear the iteration counter.
REQ-016 RUN SHALL last exactly 32 cycles, one radix-2 step per cycle: shift-add for multiply, restoring subtract for divide; the 6-bit counter SHALL go 0 to 31, then move to FIX.
REQ-017 FIX (1 cycle) SHALL apply sign correction, write HI/LO at the exiting edge, assert done, and return to IDLE.
REQ-018 Latency: start accepted at edge k -> high/low valid after edge k+34; a new start SHALL be accepted in the cycle after done.
REQ-019 Multiply: {high,low} SHALL be the 64-bit product, two's-complement for MULT and unsigned for MULTU.
REQ-020 Divide: low SHALL be the quotient truncated toward zero; high SHALL be the remainder with the dividend's sign.
REQ-021 Divisor 0 SHALL take the full latency; DIVU gives low=32'hFFFFFFFF, high=op1; DIV gives low=(op1<0 ? 32'h00000001 : 32'hFFFFFFFF), high=op1.
REQ-022 DIV 32'h80000000 / 32'hFFFFFFFF SHALL give low=32'h80000000, high=0.
REQ-023 start while busy SHALL be ignored; the caller stalls on busy.
REQ-024 wr_hi/wr_lo SHALL update high/low at the next edge only when busy=0; when busy=1 they SHALL be dropped.
REQ-025 wr_hi/wr_lo and start in the same IDLE cycle: the write SHALL apply, and the later operation result SHALL overwrite both registers.
REQ-026 abort SHALL return the FSM to IDLE at the next edge, leave high/low unchanged, and suppress done; abort in IDLE SHALL have no effect; abort SHALL beat start in the same cycle.

Reset
REQ-027 Reset SHALL force the FSM to IDLE, busy=0, done=0, high=0, low=0, counter=0, at any time including mid-operation; no partial result SHALL ever be committed.

Configuration
REQ-028 MULDIV_FAST_MULT_EN defined: MULT/MULTU SHALL go IDLE -> FIX directly, with the product formed combinationally from the latched operands (latency 2 edges, done in the cycle after accept).
REQ-029 MULDIV_FAST_MULT_EN undefined: multiply SHALL use the iterative path of REQ-016; divide SHALL be iterative in both builds.

Structure
REQ-030 Package muldiv_pkg SHALL hold the op-code constants, the FSM state enum, and ITER_COUNT=32.
REQ-031 The per-step shift/add/subtract datapath SHALL be sub-module muldiv_iter_core; FSM, counter, sign handling and HI/LO SHALL live in muldiv_sequencer.

Verification
REQ-032 MULT op1=32'hFFFFFFFE (-2), op2=3 -> after 34 edges high=32'hFFFFFFFF, low=32'hFFFFFFFA, done pulses once.
REQ-033 MULTU 32'hFFFFFFFF x 32'hFFFFFFFF -> high=32'hFFFFFFFE, low=32'h00000001.
REQ-034 DIV -7 / 2 -> low=32'hFFFFFFFD, high=32'hFFFFFFFF; DIVU 7 / 0 -> low=32'hFFFFFFFF, high=7.
REQ-035 Start, abort at RUN cycle 10 -> busy low next edge, high/low retain prior MTHI/MTLO values, no done.
REQ-036 Reset asserted at RUN cycle 20 -> all outputs 0 immediately; start while busy and wr_lo while busy both have no effect.
REQ-037 With MULDIV_FAST_MULT_EN defined, MULTU 3 x 5 -> low=15 with done in the cycle after accept.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM states and iteration count for the
// iterative multiply/divide sequencer.
package muldiv_pkg;

  localparam logic [3:0] OP_MULT  = 4'b0000;
  localparam logic [3:0] OP_MULTU = 4'b1001;
  localparam logic [3:0] OP_DIV   = 4'b1101;
  localparam logic [3:0] OP_DIVU  = 4'b1100;

  localparam int ITER_COUNT = 32;

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    RUN,
    FIX
  } state_t;

  function automatic logic op_legal(input logic [3:0] op);
    return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// One radix-2 step: shift-add multiply or restoring divide
// over the {hi, lo} accumulator pair.
module muldiv_iter_core
  import muldiv_pkg::*;
(
  input  logic        is_div,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  input  logic [31:0] operand,
  output logic [31:0] hi_nxt,
  output logic [31:0] lo_nxt
);

  logic [32:0] sum;
  logic [32:0] rem_sh;
  logic        ge;

  always_comb begin
    sum    = {1'b0, hi} + (lo[0] ? {1'b0, operand} : 33'd0);
    rem_sh = {hi, lo[31]};
    ge     = rem_sh >= {1'b0, operand};
    hi_nxt = sum[32:1];
    lo_nxt = {sum[0], lo[31:1]};
    if (is_div) begin
      hi_nxt = ge ? 32'(rem_sh - {1'b0, operand}) : rem_sh[31:0];
      lo_nxt = {lo[30:0], ge};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// Define MULDIV_FAST_MULT_EN for a single-cycle combinational multiply.
module muldiv_sequencer
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  alu_control,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic        abort,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] high,
  output logic [31:0] low
);

  state_t      state;
  logic        is_div;
  logic        is_sgn;
  logic        neg_q;
  logic        neg_r;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] m_q;
  logic [31:0] hi_acc;
  logic [31:0] lo_acc;
  logic [31:0] hi_nxt;
  logic [31:0] lo_nxt;
  logic [5:0]  cnt;
  logic [63:0] prod;
  logic [63:0] res;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        accept;

  function automatic logic [31:0] mag(input logic [31:0] x,
                                      input logic        sgn);
    return (sgn && x[31]) ? -x : x;
  endfunction

  muldiv_iter_core u_core (
    .is_div (is_div),
    .hi     (hi_acc),
    .lo     (lo_acc),
    .operand(m_q),
    .hi_nxt (hi_nxt),
    .lo_nxt (lo_nxt)
  );

  assign busy   = (state != IDLE);
  assign accept = start && !abort && op_legal(alu_control);

  always_comb begin
`ifdef MULDIV_FAST_MULT_EN
    prod = {{32{is_sgn & a_q[31]}}, a_q} * {{32{is_sgn & b_q[31]}}, b_q};
`else
    prod = {hi_acc, lo_acc};
    if (neg_q) prod = -prod;
`endif
    quo = neg_q ? -lo_acc : lo_acc;
    rem = neg_r ? -hi_acc : hi_acc;
    res = is_div ? {rem, quo} : prod;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      done   <= 1'b0;
      high   <= '0;
      low    <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      is_sgn <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      m_q    <= '0;
      hi_acc <= '0;
      lo_acc <= '0;
    end else begin
      done <= 1'b0;
      if (abort && state != IDLE) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (wr_hi) high <= wr_data;
            if (wr_lo) low  <= wr_data;
            if (accept) begin
              a_q    <= op1;
              b_q    <= op2;
              is_div <= alu_control inside {OP_DIV, OP_DIVU};
              is_sgn <= alu_control inside {OP_MULT, OP_DIV};
`ifdef MULDIV_FAST_MULT_EN
              if (alu_control inside {OP_MULT, OP_MULTU}) begin
                state <= FIX;
                done  <= 1'b1;
              end else begin
                state <= PREP;
              end
`else
              state <= PREP;
`endif
            end
          end
          PREP: begin
            hi_acc <= '0;
            lo_acc <= mag(a_q, is_sgn);
            m_q    <= mag(b_q, is_sgn);
            neg_q  <= is_sgn & (a_q[31] ^ b_q[31]);
            neg_r  <= is_sgn & a_q[31];
            cnt    <= '0;
            state  <= RUN;
          end
          RUN: begin
            hi_acc <= hi_nxt;
            lo_acc <= lo_nxt;
            cnt    <= cnt + 6'd1;
            if (cnt == 6'(ITER_COUNT - 1)) begin
              state <= FIX;
              done  <= 1'b1;
            end
          end
          FIX: begin
            high  <= res[63:32];
            low   <= res[31:0];
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: vector table,
// scoreboard queue and hand-written abort/reset/busy sequences.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  alu_control;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        abort;
  logic        wr_hi;
  logic        wr_lo;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic [31:0] high;
  logic [31:0] low;

  int tests = 0;
  int fails = 0;

  logic [63:0] sb_q[$];

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[13];

  muldiv_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .alu_control(alu_control),
    .op1        (op1),
    .op2        (op2),
    .abort      (abort),
    .wr_hi      (wr_hi),
    .wr_lo      (wr_lo),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .high       (high),
    .low        (low)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [3:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    int sa;
    int sb;
    int q;
    int r;
    sa = a;
    sb = b;
    case (op)
      OP_MULT:  return {{32{a[31]}}, a} * {{32{b[31]}}, b};
      OP_MULTU: return {32'd0, a} * {32'd0, b};
      OP_DIVU:
        if (b == 0) return {a, 32'hFFFFFFFF};
        else return {a % b, a / b};
      default: begin
        if (b == 0) return {a, (a[31] ? 32'h1 : 32'hFFFFFFFF)};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF)
          return {32'h0, 32'h80000000};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [3:0] op);
`ifdef MULDIV_FAST_MULT_EN
    if (op == OP_MULT || op == OP_MULTU) return 0;
`endif
    return 33;
  endfunction

  // Called at a negedge; drives start immediately so back-to-back
  // calls also exercise accept in the cycle after done.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp,
                       input string tag);
    int n;
    logic [63:0] e;
    start = 1'b1;
    alu_control = op;
    op1 = a;
    op2 = b;
    sb_q.push_back(exp);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, n, exp_lat(op));
    @(negedge clk);
    e = sb_q.pop_front();
    check({tag, " high"}, high, e[63:32]);
    check({tag, " low"}, low, e[31:0]);
    check({tag, " done_single"}, {31'd0, done}, 32'd0);
    check({tag, " busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [3:0] ops[4];
    logic [31:0] ra;
    logic [31:0] rb;
    int dcnt;
    logic [63:0] e;

    ops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
    vecs[0]  = '{OP_MULT,  32'hFFFFFFFE, 32'd3,
                 32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
                 32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,
                 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{OP_DIVU,  32'd7, 32'd0, 32'd7, 32'hFFFFFFFF};
    vecs[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF,
                 32'h0, 32'h80000000};
    vecs[5]  = '{OP_DIV,   32'hFFFFFFF9, 32'd0,
                 32'hFFFFFFF9, 32'h00000001};
    vecs[6]  = '{OP_DIV,   32'd7, 32'd0, 32'd7, 32'hFFFFFFFF};
    vecs[7]  = '{OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15};
    vecs[8]  = '{OP_DIVU,  32'd100, 32'd7, 32'd2, 32'd14};
    vecs[9]  = '{OP_DIV,   32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD};
    vecs[10] = '{OP_MULT,  32'h80000000, 32'h80000000,
                 32'h40000000, 32'h0};
    vecs[11] = '{OP_DIVU,  32'hFFFFFFFF, 32'd10, 32'd5, 32'h19999999};
    vecs[12] = '{OP_MULT,  32'd7, 32'hFFFFFFFF,
                 32'hFFFFFFFF, 32'hFFFFFFF9};

    reset = 1'b1;
    start = 1'b0;
    alu_control = 4'd0;
    op1 = '0;
    op2 = '0;
    abort = 1'b0;
    wr_hi = 1'b0;
    wr_lo = 1'b0;
    wr_data = '0;
    repeat (2) @(negedge clk);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst high", high, 32'd0);
    check("rst low", low, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 13; i++)
      do_op(vecs[i].op, vecs[i].a, vecs[i].b,
            {vecs[i].hi, vecs[i].lo}, $sformatf("vec%0d", i));

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = (i % 3 == 0) ? $urandom_range(0, 15) : $urandom;
      do_op(ops[i % 4], ra, rb, model(ops[i % 4], ra, rb),
            $sformatf("rnd%0d", i));
    end

    // MTHI/MTLO in IDLE
    wr_hi = 1'b1;
    wr_data = 32'h1111_1111;
    @(negedge clk);
    wr_hi = 1'b0;
    wr_lo = 1'b1;
    wr_data = 32'h2222_2222;
    @(negedge clk);
    wr_lo = 1'b0;
    check("mthi", high, 32'h1111_1111);
    check("mtlo", low, 32'h2222_2222);

    // abort at RUN cycle 10
    start = 1'b1;
    alu_control = OP_DIV;
    op1 = 32'd100;
    op2 = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    check("abort pre busy", {31'd0, busy}, 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort high", high, 32'h1111_1111);
    check("abort low", low, 32'h2222_2222);
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("abort no done", dcnt, 0);
    check("abort low kept", low, 32'h2222_2222);

    // abort beats start in IDLE; illegal opcode ignored
    abort = 1'b1;
    start = 1'b1;
    alu_control = OP_DIVU;
    @(negedge clk);
    abort = 1'b0;
    check("abort+start idle", {31'd0, busy}, 32'd0);
    alu_control = 4'b0110;
    @(negedge clk);
    start = 1'b0;
    check("illegal op", {31'd0, busy}, 32'd0);

    // write and start in the same IDLE cycle
    wr_hi = 1'b1;
    wr_data = 32'hABCD_0123;
    start = 1'b1;
    alu_control = OP_MULTU;
    op1 = 32'd3;
    op2 = 32'd5;
    sb_q.push_back(model(OP_MULTU, 32'd3, 32'd5));
    @(negedge clk);
    wr_hi = 1'b0;
    start = 1'b0;
`ifndef MULDIV_FAST_MULT_EN
    check("wr+start high", high, 32'hABCD_0123);
`endif
    dcnt = 0;
    while (!done && dcnt < 100) begin
      @(negedge clk);
      dcnt++;
    end
    @(negedge clk);
    e = sb_q.pop_front();
    check("wr+start res hi", high, e[63:32]);
    check("wr+start res lo", low, e[31:0]);

    // start and wr_lo while busy are dropped
    start = 1'b1;
    alu_control = OP_DIVU;
    op1 = 32'd100;
    op2 = 32'd7;
    sb_q.push_back(model(OP_DIVU, 32'd100, 32'd7));
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    alu_control = OP_MULTU;
    op1 = 32'd9;
    op2 = 32'd9;
    wr_lo = 1'b1;
    wr_data = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    wr_lo = 1'b0;
    check("busy wr_lo drop", low, 32'd15);
    dcnt = 0;
    while (!done && dcnt < 100) begin
      @(negedge clk);
      dcnt++;
    end
    @(negedge clk);
    e = sb_q.pop_front();
    check("busy start hi", high, e[63:32]);
    check("busy start lo", low, e[31:0]);
    @(negedge clk);
    check("busy start idle", {31'd0, busy}, 32'd0);

    // reset at RUN cycle 20
    start = 1'b1;
    alu_control = OP_DIV;
    op1 = 32'hFFFF_0000;
    op2 = 32'd13;
    @(negedge clk);
    start = 1'b0;
    repeat (21) @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid rst busy", {31'd0, busy}, 32'd0);
    check("mid rst done", {31'd0, done}, 32'd0);
    check("mid rst high", high, 32'd0);
    check("mid rst low", low, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("post rst busy", {31'd0, busy}, 32'd0);
    check("post rst low", low, 32'd0);

    do_op(OP_DIV, 32'hFFFFFFF9, 32'd2,
          {32'hFFFFFFFF, 32'hFFFFFFFD}, "after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
